slave_arbiter_r_rr: RTL

SLAVE_ARBITER_R_RR -- requirements
Module: slave_arbiter_r_rr

---
 rtl/slave_arbiter_r_rr.sv | 134 +++++++++++++
 1 files changed

// File: rtl/slave_arbiter_r_rr.sv
// Round-robin arbiter for NUM_SLV read-data (R) channels onto one master R port.
// Optional ARB_BURST_LOCK_EN: hold the grant until the RLAST beat instead of releasing per beat.
module slave_arbiter_r_rr #(
  parameter int NUM_SLV = 3,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_SLV-1:0]        s_rvalid,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV*2-1:0]      s_rresp,
  input  logic [NUM_SLV*ID_W-1:0]   s_rid,
  input  logic [NUM_SLV-1:0]        s_rlast,
  output logic [NUM_SLV-1:0]        s_rready,
  output logic                      m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                m_rresp,
  output logic [ID_W-1:0]           m_rid,
  output logic                      m_rlast,
  input  logic                      m_rready,
  output logic [NUM_SLV-1:0]        rvalid_sel,
  output logic                      busy
);

  localparam int PTR_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [NUM_SLV-1:0]   sel_q, sel_d;

  logic [2*NUM_SLV-1:0] rv_dbl;
  logic [NUM_SLV-1:0]   rv_rot;
  logic                 found;
  logic [SUM_W-1:0]     sum;
  logic [PTR_W-1:0]     pick;
  logic                 hs;
  logic                 rel;

  // Rotate requests so bit 0 is the source at ptr, then take the first set bit.
  always_comb begin
    rv_dbl = {s_rvalid, s_rvalid} >> ptr_q;
    rv_rot = rv_dbl[NUM_SLV-1:0];
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!found && rv_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + SUM_W'(k);
      end
    end
    if (sum >= SUM_W'(NUM_SLV)) begin
      sum = sum - SUM_W'(NUM_SLV);
    end
    pick = sum[PTR_W-1:0];
  end

  // One-hot mux: sel_q is all-zero outside GRANT, so every master field reads 0 in IDLE.
  always_comb begin
    m_rdata = '0;
    m_rresp = '0;
    m_rid   = '0;
    m_rlast = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        m_rdata = m_rdata | s_rdata[i*DATA_W +: DATA_W];
        m_rresp = m_rresp | s_rresp[i*2 +: 2];
        m_rid   = m_rid   | s_rid[i*ID_W +: ID_W];
        m_rlast = m_rlast | s_rlast[i];
      end
    end
  end

  assign m_rvalid   = |(sel_q & s_rvalid);
  assign s_rready   = sel_q & {NUM_SLV{m_rready}};
  assign rvalid_sel = sel_q;
  assign busy       = (state_q == GRANT);
  assign hs         = m_rvalid & m_rready;

`ifdef ARB_BURST_LOCK_EN
  assign rel = hs & m_rlast;
`else
  assign rel = hs;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gidx_d  = pick;
          sel_d   = NUM_SLV'(1) << pick;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          sel_d   = '0;
          ptr_d   = (gidx_q == PTR_W'(NUM_SLV-1)) ? '0 : gidx_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      sel_q   <= sel_d;
    end
  end

endmodule
